// File: rtl/bit_deser_pkg.sv
// bit_deser_pkg: shared state encoding and helpers for the bit deserializer.
package bit_deser_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
  localparam int MAX_WIDTH = 32;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  // Returns 1 when data plus parity bit do not have even parity.
  function automatic logic even_parity_bad(input logic [MAX_WIDTH:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/bit_deser_out_buf.sv
// bit_deser_out_buf: single-entry holding register with valid/ready output and sticky overflow.
module bit_deser_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] word,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (clr_flags) overflow <= 1'b0;
      if (push && (!dout_valid || dout_ready)) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else begin
        if (push) overflow <= 1'b1;
        if (dout_ready) dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: serial-to-parallel word assembler; define BIT_DESER_PARITY_EN for a trailing even-parity bit.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overflow,
  output logic             resync,
  output logic             parity_err,
  input  logic             clr_flags
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh, sh_nxt, sh_first, word;
  logic             push, last;
  assign sh_nxt   = MSB_FIRST ? {sh[WIDTH-2:0], din} : {din, sh[WIDTH-1:1]};
  assign sh_first = MSB_FIRST ? WIDTH'(din) : {din, {(WIDTH-1){1'b0}}};
  assign last     = cnt == CW'(WIDTH - 1);
  assign busy     = state != ST_IDLE;
`ifdef BIT_DESER_PARITY_EN
  logic perr;
  assign parity_err = perr;
  assign push       = din_valid && !frame_start && state == ST_PARITY;
  assign word       = sh;
`else
  assign parity_err = 1'b0;
  assign push       = din_valid && !frame_start && state == ST_SHIFT && last;
  assign word       = sh_nxt;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh     <= '0;
      resync <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      perr   <= 1'b0;
`endif
    end else begin
      if (clr_flags) resync <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      if (clr_flags) perr <= 1'b0;
`endif
      if (din_valid && frame_start) begin
        sh    <= sh_first;
        cnt   <= CW'(1);
        state <= ST_SHIFT;
        if (state != ST_IDLE) resync <= 1'b1;
      end else if (din_valid && state == ST_SHIFT) begin
        sh  <= sh_nxt;
        cnt <= cnt + 1'b1;
`ifdef BIT_DESER_PARITY_EN
        if (last) state <= ST_PARITY;
`else
        if (last) state <= ST_IDLE;
`endif
      end
`ifdef BIT_DESER_PARITY_EN
      else if (din_valid && state == ST_PARITY) begin
        state <= ST_IDLE;
        if (even_parity_bad((MAX_WIDTH + 1)'({sh, din}))) perr <= 1'b1;
      end
`endif
    end
  end
  bit_deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .word       (word),
    .clr_flags  (clr_flags),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow)
  );
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: scoreboard bench driving an MSB-first and an LSB-first instance in lockstep.
module tb_bit_deserializer;
  logic clk = 1'b0, rstn = 1'b0, din = 1'b0, din_valid = 1'b0, frame_start = 1'b0;
  logic dout_ready = 1'b1, clr_flags = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic dv_m, dv_l, busy_m, busy_l, ovf_m, ovf_l, rs_m, rs_l, pe_m, pe_l;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready), .busy(busy_m),
    .overflow(ovf_m), .resync(rs_m), .parity_err(pe_m), .clr_flags(clr_flags));

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready), .busy(busy_l),
    .overflow(ovf_l), .resync(rs_l), .parity_err(pe_l), .clr_flags(clr_flags));

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs, input logic c);
    din = b; din_valid = 1'b1; frame_start = fs; clr_flags = c;
    step();
    din_valid = 1'b0; frame_start = 1'b0; clr_flags = 1'b0;
  endtask

  // Sends w MSB first (w[7] is the first serial bit); MSB-first instance must return w.
  task automatic send_word(input logic [7:0] w, input logic bad_par, input bit exp, input logic clr0);
    if (exp) q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      if (i != 7 && $urandom_range(0, 3) == 0) step();
      send_bit(w[i], i == 7, i == 7 ? clr0 : 1'b0);
    end
`ifdef BIT_DESER_PARITY_EN
    send_bit(^w ^ bad_par, 1'b0, 1'b0);
`else
    if (bad_par) step();
`endif
  endtask

  always @(negedge clk) begin
    if (rstn && dv_m && dout_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", dout_m);
      end else begin
        logic [7:0] w;
        w = q.pop_front();
        chk("dout_msb", dout_m, w);
        chk("dout_lsb", dout_l, bitrev(w));
        chk("valid_lsb", dv_l, 1);
      end
    end
  end

  initial begin
    step(); step();
    chk("rst_dout", dout_m, 0);
    chk("rst_valid", dv_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_flags", {ovf_m, rs_m, pe_m}, 0);
    rstn = 1'b1;
    step();

    send_word(8'hA5, 1'b0, 1, 1'b0);
    chk("a5_valid", dv_m, 1);
    chk("a5_dout", dout_m, 8'hA5);
    chk("a5_dout_lsb", dout_l, 8'hA5);
    step();
    chk("a5_valid_pulse", dv_m, 0);
    chk("a5_busy_after", busy_m, 0);
    chk("a5_parity_err", pe_m, 0);
`ifdef BIT_DESER_PARITY_EN
    send_word(8'hA5, 1'b1, 1, 1'b0);
    chk("bad_par_err", pe_m, 1);
    chk("bad_par_dout", dout_m, 8'hA5);
    step();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("par_clr", pe_m, 0);
`endif

    send_word(8'hC0, 1'b0, 1, 1'b0);
    chk("lsb_first_03", dout_l, 8'h03);
    step();

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) send_bit(1'($urandom), 1'b0, 1'b0);
      send_word(8'($urandom), 1'b0, 1, 1'b0);
    end
    step();
    chk("rand_no_overflow", ovf_m, 0);
    chk("rand_no_resync", rs_m, 0);

    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, 1, 1'b0);
    send_word(8'h22, 1'b0, 0, 1'b0);
    step();
    chk("ovf_hold_dout", dout_m, 8'h11);
    chk("ovf_hold_valid", dv_m, 1);
    chk("ovf_flag", ovf_m, 1);
    chk("ovf_flag_lsb", ovf_l, 1);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("ovf_clr", ovf_m, 0);
    chk("ovf_clr_dout", dout_m, 8'h11);
    dout_ready = 1'b1;
    step();
    chk("ovf_popped", dv_m, 0);

    for (int i = 0; i < 4; i++) send_bit(1'($urandom), i == 0, 1'b0);
    send_word(8'hC3, 1'b0, 1, 1'b0);
    step();
    chk("resync_set", rs_m, 1);
    chk("resync_set_lsb", rs_l, 1);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("resync_clr", rs_m, 0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), i == 0, 1'b0);
    send_word(8'h5C, 1'b0, 1, 1'b1);
    step();
    chk("resync_set_wins", rs_m, 1);

    for (int i = 0; i < 5; i++) send_bit(1'($urandom), i == 0, 1'b0);
    rstn = 1'b0;
    din = 1'b1; din_valid = 1'b1;
    step(); step();
    din_valid = 1'b0;
    chk("midrst_dout", dout_m, 0);
    chk("midrst_valid", dv_m, 0);
    chk("midrst_busy", busy_m, 0);
    chk("midrst_flags", {ovf_m, rs_m, pe_m}, 0);
    rstn = 1'b1;
    step();
    send_word(8'h7E, 1'b0, 1, 1'b0);
    chk("post_rst_dout", dout_m, 8'h7E);

    for (int t = 0; t < 20 && q.size() > 0; t++) step();
    chk("scoreboard_drained", q.size(), 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Serial-to-parallel stage directly downstream of the single-bit D flip-flop model.
- Consumes the registered bit stream (the flop's q) and assembles WIDTH-bit words.
- Presents each assembled word on a valid/ready output with a single-entry holding register, plus sticky error flags.
- Used as the digital-side word assembler in mixed-signal NGHDL co-simulation benches.

Parameters:
- WIDTH, 8: data bits per word, legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- din  input  1  serial data bit (registered q from the upstream flop).
- din_valid  input  1  din is sampled only on edges where din_valid=1.
- frame_start  input  1  qualified by din_valid; marks din as bit 0 of a new word.
- dout  output  WIDTH  assembled word; stable while dout_valid=1 and dout_ready=0.
- dout_valid  output  1  word available.
- dout_ready  input  1  consumer accepts when dout_valid&dout_ready.
- busy  output  1  high in SHIFT or PARITY state.
- overflow  output  1  sticky: a completed word was dropped because the holding register was full.
- resync  output  1  sticky: frame_start arrived mid-word.
- parity_err  output  1  sticky parity mismatch (see Optional Feature).
- clr_flags  input  1  single-cycle clear of all sticky flags.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, bit count=0, shift register=0.
  - dout=0, dout_valid=0, busy=0, overflow=0, resync=0, parity_err=0.
  - Reset mid-word discards the partial word and any held word.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - On din_valid&frame_start: capture din as bit 0, count=1, go to SHIFT.
  - din_valid without frame_start is ignored.
- SHIFT:
  - Each din_valid edge captures one bit and increments count.
  - On capture of bit WIDTH-1: the word is complete; go to PARITY (macro) or IDLE.
  - din_valid=0 stalls; no timeout.
- frame_start with din_valid while in SHIFT/PARITY:
  - Abandon the partial word and set resync.
  - Treat din as bit 0 of a new word, count=1, state=SHIFT.
- Completion and output handshake:
  - The word is written to the holding register on the completing edge; dout_valid rises in the next cycle (latency 0 cycles after the last bit edge).
  - Holding register empty, or being popped this same edge (dout_valid&dout_ready): load the new word, dout_valid=1.
  - Otherwise: drop the new word, keep the old one, set overflow.
  - dout_valid clears on pop unless a new word loads on the same edge.
- clr_flags and a flag set on the same edge: the set wins.
- Back-to-back frames: frame_start on the cycle after completion is accepted with no gap cycle.
- WIDTH=2 is legal: completion occurs on the second captured bit.

Optional Feature:
- Macro: BIT_DESER_PARITY_EN.
- Defined:
  - After bit WIDTH-1, go to PARITY and wait for one more din_valid bit.
  - Even parity over data plus parity bit is required.
  - Mismatch sets parity_err; the word is still delivered.
  - The word completes on the parity-bit edge, not the last data edge.
  - frame_start in PARITY is handled as a resync.
- Undefined:
  - PARITY state absent; completion on bit WIDTH-1.
  - parity_err tied to 0; port list unchanged.

Decomposition:
- Package bit_deser_pkg:
  - State enum typedef (ST_IDLE, ST_SHIFT, ST_PARITY).
  - Count width constant derived from WIDTH via $clog2(WIDTH+1).
  - Even-parity helper function.
- One sub-module, bit_deser_out_buf: holding register, dout/dout_valid, push/pop arbitration, overflow flag generation.
- The top contains the FSM, the shift register and the resync/parity flags.

Test Plan:
- WIDTH=8, MSB_FIRST=1: serial bits 1,0,1,0,0,1,0,1 with frame_start on the first bit, dout_ready=1 -> dout=8'hA5, dout_valid high for exactly 1 cycle, busy low after.
- MSB_FIRST=0, same bit sequence -> dout=8'hA5 reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> dout=8'h03.
- dout_ready=0, send 8'h11 then 8'h22 -> dout stays 8'h11, overflow=1; pulse clr_flags -> overflow=0; raise dout_ready -> 8'h11 popped, dout_valid=0.
- frame_start asserted at bit 4 of a word, then 8 clean bits 8'hC3 -> resync=1, single output 8'hC3.
- Pull rstn low (sync) at bit 5, release, send 8'h7E -> no output during reset, all outputs 0, then dout=8'h7E.
- BIT_DESER_PARITY_EN: 8'hA5 with parity bit 0 -> parity_err=0; 8'hA5 with parity bit 1 -> parity_err=1 and dout=8'hA5 still delivered.
